// File: rtl/lmem_arbiter.sv
// Shared layer-memory port arbiter for the CNN accelerator.
// Requesters: 0 = conv writer, 1 = max-pool engine, 2 = host dump (read-only).
// One command per cycle is granted (combinational gnt), registered onto the
// memory port the next cycle, and read data returns to the issuer one cycle
// after that. A requester may lock the port for atomic bursts; a locked owner
// that goes LOCK_TMO cycles without a grant is forcibly released.
// Build option: define LMEM_ARB_RR_EN for round-robin arbitration while OPEN;
// otherwise fixed priority 0 > 1 > 2 is used.
//
// state      | meaning
// ST_OPEN    | any requester eligible, arbitration by priority/round-robin
// ST_LOCKED  | only owner_q may be granted; timeout counter runs when idle
module lmem_arbiter #(
    parameter int AW       = 12,
    parameter int DW       = 20,
    parameter int LOCK_TMO = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        req,
    input  logic [2:0]        lock,
    input  logic [2:0]        we,
    input  logic [3*AW-1:0]   addr_i,
    input  logic [3*DW-1:0]   wdata_i,
    input  logic [8:0]        sel_i,
    output logic [2:0]        gnt,
    output logic [2:0]        rvalid,
    output logic [DW-1:0]     rdata,
    output logic              lock_err,
    output logic              cwr,
    output logic              crd,
    output logic [AW-1:0]     caddr_wr,
    output logic [AW-1:0]     caddr_rd,
    output logic [DW-1:0]     cdata_wr,
    output logic [2:0]        csel,
    input  logic [DW-1:0]     cdata_rd
);

    localparam int TW = $clog2(LOCK_TMO + 1);

    typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

    state_t          state_q;
    logic [1:0]      owner_q;
    logic [TW-1:0]   tmo_q;
    logic            lock_err_q;

    logic            cwr_q, crd_q;
    logic [AW-1:0]   caddr_wr_q, caddr_rd_q;
    logic [DW-1:0]   cdata_wr_q;
    logic [2:0]      csel_q;
    logic [2:0]      rd_oh_q;
    logic [2:0]      rvalid_q;
    logic [DW-1:0]   rdata_q;

    logic [2:0]      gnt_d;
    logic [1:0]      gidx;
    logic            any_gnt;
    logic            is_wr;
    logic [2:0]      owner_oh;
    logic            own_req, own_lock;
    logic [1:0]      arb_start;
    logic [AW-1:0]   addr_sel;
    logic [DW-1:0]   wdata_sel;
    logic [2:0]      sel_sel;

    // Priority pick among the three requesters starting at index 'start'.
    function automatic logic [2:0] pick_from(input logic [2:0] r, input logic [1:0] start);
        logic [2:0] g;
        g = 3'b000;
        case (start)
            2'd1: begin
                if (r[1])      g = 3'b010;
                else if (r[2]) g = 3'b100;
                else if (r[0]) g = 3'b001;
            end
            2'd2: begin
                if (r[2])      g = 3'b100;
                else if (r[0]) g = 3'b001;
                else if (r[1]) g = 3'b010;
            end
            default: begin
                if (r[0])      g = 3'b001;
                else if (r[1]) g = 3'b010;
                else if (r[2]) g = 3'b100;
            end
        endcase
        return g;
    endfunction

`ifdef LMEM_ARB_RR_EN
    logic [1:0] last_gnt_q;

    // Round-robin pointer: remembers the most recently granted requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_gnt_q <= 2'd2;
        end else if (any_gnt) begin
            last_gnt_q <= gidx;
        end
    end

    assign arb_start = (last_gnt_q == 2'd2) ? 2'd0 : last_gnt_q + 2'd1;
`else
    assign arb_start = 2'd0;
`endif

    // Owner decode and grant generation; reset masks requests.
    always_comb begin
        owner_oh = 3'b001;
        case (owner_q)
            2'd1:    owner_oh = 3'b010;
            2'd2:    owner_oh = 3'b100;
            default: owner_oh = 3'b001;
        endcase
        own_req  = |(req & owner_oh);
        own_lock = |(lock & owner_oh);
        gnt_d    = 3'b000;
        if (!reset) begin
            if (state_q == ST_LOCKED) gnt_d = req & owner_oh;
            else                      gnt_d = pick_from(req, arb_start);
        end
    end

    // Granted-requester command mux; requester 2 never writes.
    always_comb begin
        any_gnt = |gnt_d;
        case (gnt_d)
            3'b010:  gidx = 2'd1;
            3'b100:  gidx = 2'd2;
            default: gidx = 2'd0;
        endcase
        is_wr = we[gidx] && (gidx != 2'd2);
        case (gidx)
            2'd1: begin
                addr_sel  = addr_i[2*AW-1:AW];
                wdata_sel = wdata_i[2*DW-1:DW];
                sel_sel   = sel_i[5:3];
            end
            2'd2: begin
                addr_sel  = addr_i[3*AW-1:2*AW];
                wdata_sel = wdata_i[3*DW-1:2*DW];
                sel_sel   = sel_i[8:6];
            end
            default: begin
                addr_sel  = addr_i[AW-1:0];
                wdata_sel = wdata_i[DW-1:0];
                sel_sel   = sel_i[2:0];
            end
        endcase
    end

    // Lock FSM: ownership tracking, idle timeout and forced-release pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_OPEN;
            owner_q    <= 2'd0;
            tmo_q      <= '0;
            lock_err_q <= 1'b0;
        end else begin
            lock_err_q <= 1'b0;
            if (any_gnt) begin
                // A grant always wins over a same-cycle timeout.
                tmo_q <= '0;
                if (|(lock & gnt_d)) begin
                    state_q <= ST_LOCKED;
                    owner_q <= gidx;
                end else begin
                    state_q <= ST_OPEN;
                end
            end else if (state_q == ST_LOCKED) begin
                if (!own_req && !own_lock) begin
                    state_q <= ST_OPEN;
                    tmo_q   <= '0;
                end else if (tmo_q == TW'(LOCK_TMO - 1)) begin
                    state_q    <= ST_OPEN;
                    tmo_q      <= '0;
                    lock_err_q <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + TW'(1);
                end
            end
        end
    end

    // Memory command stage and read-return pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
            cdata_wr_q <= '0;
            csel_q     <= '0;
            rd_oh_q    <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            cwr_q    <= any_gnt && is_wr;
            crd_q    <= any_gnt && !is_wr;
            rd_oh_q  <= (any_gnt && !is_wr) ? gnt_d : 3'b000;
            rvalid_q <= crd_q ? rd_oh_q : 3'b000;
            if (crd_q) rdata_q <= cdata_rd;
            if (any_gnt) begin
                csel_q <= sel_sel;
                if (is_wr) begin
                    caddr_wr_q <= addr_sel;
                    cdata_wr_q <= wdata_sel;
                end else begin
                    caddr_rd_q <= addr_sel;
                end
            end
        end
    end

    assign gnt      = gnt_d;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign lock_err = lock_err_q;
    assign cwr      = cwr_q;
    assign crd      = crd_q;
    assign caddr_wr = caddr_wr_q;
    assign caddr_rd = caddr_rd_q;
    assign cdata_wr = cdata_wr_q;
    assign csel     = csel_q;

endmodule

// File: tb/tb_lmem_arbiter.sv
// Scoreboard bench for lmem_arbiter: stimulus pushes expected memory commands
// and read returns (with their due cycle); a negedge monitor pops and compares.
module tb_lmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 20;

    logic            clk;
    logic            reset;
    logic [2:0]      req, lock, we;
    logic [AW-1:0]   addr_r  [3];
    logic [DW-1:0]   wdata_r [3];
    logic [2:0]      sel_r   [3];
    logic [3*AW-1:0] addr_i;
    logic [3*DW-1:0] wdata_i;
    logic [8:0]      sel_i;
    logic [2:0]      gnt, rvalid, csel;
    logic [DW-1:0]   rdata, cdata_wr, cdata_rd;
    logic            lock_err, cwr, crd;
    logic [AW-1:0]   caddr_wr, caddr_rd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    sel;
        int            cyc;
    } cmd_t;

    typedef struct {
        logic [2:0]    oh;
        logic [DW-1:0] data;
        int            cyc;
    } rd_t;

    cmd_t exp_cmd[$];
    rd_t  exp_rd[$];

    assign addr_i  = {addr_r[2], addr_r[1], addr_r[0]};
    assign wdata_i = {wdata_r[2], wdata_r[1], wdata_r[0]};
    assign sel_i   = {sel_r[2], sel_r[1], sel_r[0]};

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return (a == 12'h123) ? 20'hABCDE : {a, 8'h3C};
    endfunction

    assign cdata_rd = memf(caddr_rd);

    lmem_arbiter #(.AW(AW), .DW(DW), .LOCK_TMO(16)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
        .addr_i(addr_i), .wdata_i(wdata_i), .sel_i(sel_i),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .lock_err(lock_err),
        .cwr(cwr), .crd(crd), .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
        .cdata_wr(cdata_wr), .csel(csel), .cdata_rd(cdata_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compare every memory strobe and read return against the queues.
    always @(negedge clk) begin
        cmd_t ec;
        rd_t  er;
        if (!reset) begin
            if (cwr || crd) begin
                if (exp_cmd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cmd_unexpected actual cwr=%0b crd=%0b required none (cycle %0d)", cwr, crd, cyc);
                end else begin
                    ec = exp_cmd.pop_front();
                    chk("cmd_cycle", 32'(cyc), 32'(ec.cyc));
                    chk("cwr", 32'(cwr), 32'(ec.wr));
                    chk("crd", 32'(crd), 32'(!ec.wr));
                    chk("csel", 32'(csel), 32'(ec.sel));
                    if (ec.wr) begin
                        chk("caddr_wr", 32'(caddr_wr), 32'(ec.addr));
                        chk("cdata_wr", 32'(cdata_wr), 32'(ec.data));
                    end else begin
                        chk("caddr_rd", 32'(caddr_rd), 32'(ec.addr));
                    end
                end
            end
            if (|rvalid) begin
                if (exp_rd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rvalid_unexpected actual=%0b required none (cycle %0d)", rvalid, cyc);
                end else begin
                    er = exp_rd.pop_front();
                    chk("rvalid_cycle", 32'(cyc), 32'(er.cyc));
                    chk("rvalid", 32'(rvalid), 32'(er.oh));
                    chk("rdata", 32'(rdata), 32'(er.data));
                end
            end
        end
    end

    // One cycle: check gnt/lock_err, queue expectations for a grant, advance.
    task automatic expect_cycle(input logic [2:0] eg, input logic el);
        int   k;
        logic w;
        cmd_t c;
        rd_t  r;
        #2;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("lock_err", 32'(lock_err), 32'(el));
        if (eg != 3'b000) begin
            k = (eg == 3'b001) ? 0 : (eg == 3'b010) ? 1 : 2;
            w = we[k] && (k != 2);
            c.wr = w; c.addr = addr_r[k]; c.data = wdata_r[k]; c.sel = sel_r[k]; c.cyc = cyc + 1;
            exp_cmd.push_back(c);
            if (!w) begin
                r.oh = eg; r.data = memf(addr_r[k]); r.cyc = cyc + 2;
                exp_rd.push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) expect_cycle(3'b000, 1'b0);
    endtask

    task automatic do_reset();
        chk("cmd_q_drained", 32'(exp_cmd.size()), 32'd0);
        chk("rd_q_drained", 32'(exp_rd.size()), 32'd0);
        reset = 1'b1;
        req = '0; lock = '0; we = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req = 3'b111; lock = 3'b111; we = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr_r[i] = '0; wdata_r[i] = '0; sel_r[i] = '0;
        end
        #3;
        // Reset state: everything zero, requests ignored.
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_outs", 32'({cwr, crd, rvalid, lock_err, csel}), 32'd0);
        chk("rst_data", 32'(rdata | cdata_wr), 32'd0);
        chk("rst_addr", 32'({caddr_wr, caddr_rd}), 32'd0);
        req = '0; lock = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single read by requester 2.
        addr_r[2] = 12'h123; sel_r[2] = 3'b010; req = 3'b100;
        expect_cycle(3'b100, 1'b0);
        req = '0;
        idle(3);

        // Requester 2 with we=1 is still a read.
        we = 3'b100; sel_r[2] = 3'b110; req = 3'b100;
        expect_cycle(3'b100, 1'b0);
        req = '0; we = '0;
        idle(3);

        // Write path, then address/select hold while idle.
        addr_r[0] = 12'hFFF; wdata_r[0] = 20'h13100; sel_r[0] = 3'b001; we = 3'b001; req = 3'b001;
        expect_cycle(3'b001, 1'b0);
        req = '0; we = '0;
        idle(3);
        chk("caddr_wr_hold", 32'(caddr_wr), 32'h0FFF);
        chk("csel_hold", 32'(csel), 32'd1);

        // Contention with all three held (reads).
        do_reset();
        addr_r[0] = 12'h010; addr_r[1] = 12'h020; addr_r[2] = 12'h030;
        sel_r[0] = 3'b001; sel_r[1] = 3'b010; sel_r[2] = 3'b100;
        req = 3'b111;
`ifdef LMEM_ARB_RR_EN
        expect_cycle(3'b001, 1'b0);
        expect_cycle(3'b010, 1'b0);
        expect_cycle(3'b100, 1'b0);
        expect_cycle(3'b001, 1'b0);
`else
        for (int i = 0; i < 4; i++) expect_cycle(3'b001, 1'b0);
`endif
        req = '0;
        idle(4);

        // Locked max-pool burst while requester 0 waits.
        sel_r[1] = 3'b011; addr_r[1] = 12'h000; lock = 3'b010; req = 3'b010;
        expect_cycle(3'b010, 1'b0);
        addr_r[0] = 12'h200; wdata_r[0] = 20'h55555; sel_r[0] = 3'b100; we = 3'b001;
        req = 3'b011;
        addr_r[1] = 12'h001; expect_cycle(3'b010, 1'b0);
        addr_r[1] = 12'h040; expect_cycle(3'b010, 1'b0);
        addr_r[1] = 12'h041; expect_cycle(3'b010, 1'b0);
        addr_r[1] = 12'h000; wdata_r[1] = 20'h0BEEF; we = 3'b011; lock = 3'b000;
        expect_cycle(3'b010, 1'b0);
        req = 3'b001; we = 3'b001;
        expect_cycle(3'b001, 1'b0);
        req = '0; we = '0;
        idle(3);

        // Lock timeout: owner idles with lock held for 16 cycles.
        addr_r[1] = 12'h050; lock = 3'b010; req = 3'b010;
        expect_cycle(3'b010, 1'b0);
        addr_r[0] = 12'h060; req = 3'b001;
        idle(16);
        expect_cycle(3'b001, 1'b1);
        req = '0; lock = '0;
        idle(3);

        // Owner drops req and lock together: released without error.
        addr_r[1] = 12'h070; lock = 3'b010; req = 3'b010;
        expect_cycle(3'b010, 1'b0);
        addr_r[0] = 12'h080; lock = '0; req = 3'b001;
        expect_cycle(3'b000, 1'b0);
        expect_cycle(3'b001, 1'b0);
        req = '0;
        idle(3);

        // Reset between grant and rvalid.
        addr_r[2] = 12'h0AA; req = 3'b100;
        expect_cycle(3'b100, 1'b0);
        req = '0;
        chk("pre_reset_crd", 32'(crd), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_strobes", 32'({cwr, crd}), 32'd0);
        chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
        chk("mid_rst_addr", 32'({caddr_wr, caddr_rd}), 32'd0);
        chk("mid_rst_misc", 32'({csel, lock_err, gnt}), 32'd0);
        chk("mid_rst_data", 32'(rdata | cdata_wr), 32'd0);
        exp_cmd.delete();
        exp_rd.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);

        chk("end_cmd_q_empty", 32'(exp_cmd.size()), 32'd0);
        chk("end_rd_q_empty", 32'(exp_rd.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lmem_arbiter.md
# lmem_arbiter

Arbiter for the single shared layer-memory port (cwr/crd/caddr_wr/caddr_rd/cdata_wr/cdata_rd/csel) used by the CNN accelerator. It serves three requesters: 0 = convolution writer (L0), 1 = max-pool engine (reads L0, writes L1), 2 = host/debug dump reader. Each cycle it grants at most one requester, registers that requester's command onto the memory port and returns read data to the issuing requester. A lock mechanism lets one requester take atomic bursts, such as the 4-read/1-write maxpool window.

## Interface
Parameters
- AW, 12, memory address width
- DW, 20, memory data width
- LOCK_TMO, 16, cycles a locked owner may go ungranted before forced release

Ports (reset reset, asynchronous, active-high; clock clk)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous active-high reset
- req  in  3  per-requester command valid; held with command until granted
- lock  in  3  per-requester: keep ownership after this grant
- we  in  3  per-requester: 1 = write, 0 = read
- addr_i  in  3*AW  per-requester address, requester k at [k*AW +: AW]
- wdata_i  in  3*DW  per-requester write data
- sel_i  in  9  per-requester memory bank select (csel value)
- gnt  out  3  combinational one-hot grant; command accepted this cycle
- rvalid  out  3  registered one-hot read-data valid
- rdata  out  DW  registered read data, valid when any rvalid bit is high
- lock_err  out  1  one-cycle pulse on forced lock release
- cwr, crd  out  1 each  memory write / read strobe (registered)
- caddr_wr, caddr_rd  out  AW each  memory write / read address (registered)
- cdata_wr  out  DW  memory write data (registered)
- csel  out  3  memory bank select (registered)
- cdata_rd  in  DW  memory read data, valid in the same cycle crd/caddr_rd are presented

## Operation
- States: OPEN (any requester eligible) and LOCKED (owner only).
- OPEN, fixed priority (default): grant the lowest-index requester with req=1.
- OPEN with round-robin (see Configuration): search starts at last_gnt+1 mod 3. last_gnt is updated on every grant.
- Grant to k with lock[k]=1 moves the block to LOCKED with owner=k. Grant with lock[k]=0 keeps or returns the block to OPEN.
- LOCKED: gnt[owner]=req[owner], and other requesters are never granted.
  - Exit to OPEN when the owner is granted with lock=0.
  - Exit to OPEN when the owner drops both req and lock in the same cycle.
- Lock timeout:
  - The counter counts LOCKED cycles without a grant and clears on every grant.
  - When it reaches LOCK_TMO, the block returns to OPEN, lock_err pulses and the counter clears. The owner loses ownership.
- Write grant: the next cycle has cwr=1, caddr_wr=addr, cdata_wr=wdata and csel=sel of the granted requester, with crd=0.
- Read grant: the next cycle has crd=1, caddr_rd=addr and csel=sel, with cwr=0.
  - cdata_rd is captured at the end of that cycle.
  - The following cycle has rvalid[k]=1 and rdata=captured value.
- No grant: the next cycle has cwr=crd=0. Addresses, cdata_wr and csel hold their previous values.
- req=1 with no grant: the requester must hold addr/we/wdata/sel unchanged.
- Requester 2 is read-only. A grant to 2 with we[2]=1 is issued as a read.

## Timing
- Reset values:
  - all outputs 0 (gnt is combinational, 0 because the state is OPEN and req is ignored while reset is high);
  - state OPEN, owner 0, last_gnt 2 (requester 0 first), timeout counter 0.
- Issue rate: one command per cycle, back-to-back across requesters with no bubble.
- Latency:
  - gnt in cycle N;
  - memory strobe in N+1;
  - read data on rdata/rvalid in N+2.
- Read pipeline: two reads can be in flight. The rvalid order equals the grant order.
- Simultaneous events:
  - owner granted with lock=0 and another requester pending: the other requester can be granted from N+1.
  - timeout and owner req in the same cycle: the owner is granted and the counter clears, so the grant wins.
- Reset mid-operation clears the pipeline immediately. In-flight rvalid is dropped and cwr/crd deassert asynchronously.

## Configuration
- LMEM_ARB_RR_EN defined: round-robin arbitration in OPEN, using the last_gnt pointer.
- LMEM_ARB_RR_EN undefined: fixed priority 0 > 1 > 2. The last_gnt register is not implemented.
- LOCKED behaviour is identical in both builds.

## Test plan
- Single read: req[2]=1, we=0, addr=0x123, memory returns 0xABCDE. Expect gnt[2] in N, crd=1 and caddr_rd=0x123 in N+1, rvalid[2]=1 and rdata=0xABCDE in N+2.
- Contention, fixed build: req=3'b111, all held. Expect the grant order 0,0,0… (requester 0 starves the others). In the RR build expect 0,1,2,0 on consecutive cycles.
- Locked burst: requester 1 issues 4 reads of 0x000/0x001/0x040/0x041 with lock=1, then a write to 0x000 with lock=0 and csel=3'b011, while req[0] is held. Expect requester 0 not granted during the 5 beats and granted in the cycle after the write grant.
- Lock timeout: requester 1 is granted with lock=1, then holds req=0 and lock=1 for 16 cycles. Expect lock_err to pulse once, after which a pending req[0] is granted.
- Write path: requester 0 writes addr=0xFFF, data=0x13100, sel=1. Expect cwr=1, caddr_wr=0xFFF, cdata_wr=0x13100 and csel=3'b001 for exactly one cycle.
- Reset during read: assert reset between gnt and rvalid. Expect rvalid=0 and cwr=crd=0 immediately, with every output back at 0.
